// File: rtl/rwg_pkg.sv
// Shared types for the read wait-state generator.
// State names follow the controller state expected this cycle.
package rwg_pkg;

  localparam int WCW = 4;

  typedef enum logic [1:0] {
    IDLE,
    TREAD,
    TDLY,
    TDONE
  } state_e;

endpackage

// File: rtl/wrap_counter.sv
// Free-running enable counter that wraps modulo 2^W.
// Used for the completed-transfer count.
module wrap_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign cnt_d = cnt_q + W'(1);
  assign cnt_o = cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/read_wait_gen.sv
// Tracks a READ/DLY/DONE controller, inserts wait states,
// captures device data and flags protocol violations.
module read_wait_gen
  import rwg_pkg::*;
#(
  parameter int DW = 8,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rd,
  input  logic          ds,
  input  logic [3:0]    wait_cfg,
  input  logic [DW-1:0] dev_data,
  input  logic          err_clr,
  output logic          ws,
  output logic [DW-1:0] rdata,
  output logic          rvalid,
  output logic          busy,
  output logic          err,
  output logic [CW-1:0] xfer_cnt
);

  state_e           state_q, state_d;
  logic [WCW-1:0]   wcnt_q, wcnt_d;
  logic [DW-1:0]    rdata_q, rdata_d;
  logic             err_q, err_d;
  logic             viol;
  logic             cnt_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    rdata_d = rdata_q;
    viol    = 1'b0;
    cnt_en  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rd) begin
          state_d = TDLY;
          wcnt_d  = wait_cfg;
        end else if (ds) begin
          viol = 1'b1;
        end
      end
      TDLY: begin
        if (!rd) begin
          viol    = 1'b1;
          state_d = IDLE;
        end else if (wcnt_q != '0) begin
          wcnt_d  = wcnt_q - WCW'(1);
          state_d = TREAD;
        end else begin
          rdata_d = dev_data;
          state_d = TDONE;
        end
      end
      TREAD: begin
        if (rd) begin
          state_d = TDLY;
        end else begin
          viol    = 1'b1;
          state_d = IDLE;
        end
      end
      TDONE: begin
        state_d = IDLE;
        if (ds && !rd) begin
          cnt_en = 1'b1;
        end else begin
          viol = 1'b1;
        end
      end
    endcase
    // a new violation overrides a simultaneous clear
    err_d  = viol | (err_q & ~err_clr);
    ws     = (state_q == TDLY) && (wcnt_q != '0);
    rvalid = (state_q == TDONE);
    busy   = (state_q != IDLE);
  end

  assign rdata = rdata_q;
  assign err   = err_q;

  wrap_counter #(
    .W(CW)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .en   (cnt_en),
    .cnt_o(xfer_cnt)
  );

endmodule

// File: tb/tb_read_wait_gen.sv
// Directed bench for read_wait_gen with a position-based
// protocol model and per-cycle output comparison.
module tb_read_wait_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd;
  logic        ds;
  logic [3:0]  wait_cfg;
  logic [7:0]  dev_data;
  logic        err_clr;
  logic        ws;
  logic [7:0]  rdata;
  logic        rvalid;
  logic        busy;
  logic        err;
  logic [15:0] xfer_cnt;

  read_wait_gen #(.DW(8), .CW(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .rd      (rd),
    .ds      (ds),
    .wait_cfg(wait_cfg),
    .dev_data(dev_data),
    .err_clr (err_clr),
    .ws      (ws),
    .rdata   (rdata),
    .rvalid  (rvalid),
    .busy    (busy),
    .err     (err),
    .xfer_cnt(xfer_cnt)
  );

  always #5 clk = ~clk;

  // model: m_acc = cycle position inside an access (0 = idle)
  int          m_acc;
  int          m_n;
  logic        m_err;
  logic [7:0]  m_rdata;
  logic [15:0] m_cnt;

  int          total;
  int          bad;

  string       lnm  [64];
  logic [31:0] lact [64];
  logic [31:0] lexp [64];
  int          lwr;
  int          lrd;

  function automatic logic e_busy();
    return m_acc >= 2;
  endfunction

  function automatic logic e_ws();
    return (m_acc >= 2) && (m_acc % 2 == 0) && (m_acc <= 2 * m_n);
  endfunction

  function automatic logic e_rvalid();
    return (m_acc != 0) && (m_acc == 2 * m_n + 3);
  endfunction

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, a, e, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("ws", 32'(ws), 32'(e_ws()));
    chk("busy", 32'(busy), 32'(e_busy()));
    chk("rvalid", 32'(rvalid), 32'(e_rvalid()));
    chk("err", 32'(err), 32'(m_err));
    chk("rdata", 32'(rdata), 32'(m_rdata));
    chk("xfer_cnt", 32'(xfer_cnt), 32'(m_cnt));
    while (lrd < lwr) begin
      chk(lnm[lrd], lact[lrd], lexp[lrd]);
      lrd++;
    end
  end

  task automatic lit(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    if (lwr < 64) begin
      lnm[lwr]  = nm;
      lact[lwr] = a;
      lexp[lwr] = e;
      lwr++;
    end
  endtask

  task automatic model_reset();
    m_acc   = 0;
    m_n     = 0;
    m_err   = 1'b0;
    m_rdata = 8'h00;
    m_cnt   = 16'h0000;
  endtask

  task automatic step();
    logic v;
    v = 1'b0;
    if (m_acc == 0) begin
      if (rd) begin
        m_acc = 2;
        m_n   = int'(wait_cfg);
      end else if (ds) begin
        v = 1'b1;
      end
    end else if (m_acc <= 2 * m_n + 2) begin
      if (rd) begin
        if (m_acc == 2 * m_n + 2) m_rdata = dev_data;
        m_acc++;
      end else begin
        v     = 1'b1;
        m_acc = 0;
      end
    end else begin
      if (ds && !rd) m_cnt = m_cnt + 16'd1;
      else v = 1'b1;
      m_acc = 0;
    end
    m_err = v ? 1'b1 : (err_clr ? 1'b0 : m_err);
  endtask

  task automatic cyc(input logic r, input logic d);
    rd = r;
    ds = d;
    @(posedge clk);
    step();
    #1;
  endtask

  task automatic access(input logic [3:0] n, input logic [3:0] n2,
                        input logic [7:0] dat, input int rdcyc,
                        output logic [15:0] wsb, output logic rv);
    wsb      = '0;
    wait_cfg = n;
    dev_data = dat;
    for (int i = 0; i < rdcyc; i++) begin
      rd     = 1'b1;
      ds     = 1'b0;
      wsb[i] = ws;
      @(posedge clk);
      step();
      #1;
      wait_cfg = n2;
    end
    rd = 1'b0;
    ds = 1'b1;
    rv = rvalid;
    @(posedge clk);
    step();
    #1;
    ds = 1'b0;
  endtask

  logic [15:0] wsb;
  logic        rv;

  initial begin
    total    = 0;
    bad      = 0;
    lwr      = 0;
    lrd      = 0;
    rst      = 1'b1;
    rd       = 1'b0;
    ds       = 1'b0;
    wait_cfg = 4'd0;
    dev_data = 8'h00;
    err_clr  = 1'b0;
    model_reset();
    #12;
    lit("rst_ws", 32'(ws), 0);
    lit("rst_busy", 32'(busy), 0);
    lit("rst_rvalid", 32'(rvalid), 0);
    lit("rst_err", 32'(err), 0);
    lit("rst_rdata", 32'(rdata), 0);
    lit("rst_cnt", 32'(xfer_cnt), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    cyc(1'b0, 1'b0);

    access(4'd0, 4'd0, 8'hA5, 2, wsb, rv);
    lit("s1_ws", 32'(wsb), 0);
    lit("s1_rvalid", 32'(rv), 1);
    lit("s1_rdata", 32'(rdata), 32'hA5);
    lit("s1_cnt", 32'(xfer_cnt), 1);
    lit("s1_err", 32'(err), 0);

    access(4'd3, 4'd3, 8'h3C, 8, wsb, rv);
    lit("s2_ws", 32'(wsb), 32'h2A);
    lit("s2_rvalid", 32'(rv), 1);
    lit("s2_cnt", 32'(xfer_cnt), 2);
    lit("s2_rdata", 32'(rdata), 32'h3C);

    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    lit("s3_err", 32'(err), 1);
    lit("s3_busy", 32'(busy), 0);
    lit("s3_cnt", 32'(xfer_cnt), 2);
    err_clr = 1'b1;
    cyc(1'b0, 1'b0);
    err_clr = 1'b0;
    lit("s3_clr", 32'(err), 0);

    cyc(1'b0, 1'b1);
    lit("s4_err", 32'(err), 1);
    access(4'd0, 4'd0, 8'h5A, 2, wsb, rv);
    lit("s4_cnt", 32'(xfer_cnt), 3);
    lit("s4_rdata", 32'(rdata), 32'h5A);
    lit("s4_sticky", 32'(err), 1);
    err_clr = 1'b1;
    cyc(1'b0, 1'b1);
    err_clr = 1'b0;
    lit("set_wins", 32'(err), 1);
    err_clr = 1'b1;
    cyc(1'b0, 1'b0);
    err_clr = 1'b0;

    wait_cfg = 4'd0;
    dev_data = 8'h77;
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    dev_data = 8'h11;
    cyc(1'b1, 1'b0);
    lit("abort_err", 32'(err), 1);
    lit("abort_rdata", 32'(rdata), 32'h77);
    lit("abort_cnt", 32'(xfer_cnt), 3);
    access(4'd0, 4'd0, 8'h99, 2, wsb, rv);
    lit("fresh_cnt", 32'(xfer_cnt), 4);
    lit("fresh_rdata", 32'(rdata), 32'h99);

    wait_cfg = 4'd2;
    cyc(1'b1, 1'b0);
    lit("s5_pre_ws", 32'(ws), 1);
    #1;
    rst = 1'b1;
    rd  = 1'b0;
    model_reset();
    #1;
    lit("s5_ws", 32'(ws), 0);
    lit("s5_busy", 32'(busy), 0);
    lit("s5_cnt", 32'(xfer_cnt), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(1'b0, 1'b0);

    force dut.u_cnt.cnt_q = 16'hFFFF;
    #1;
    release dut.u_cnt.cnt_q;
    m_cnt = 16'hFFFF;
    @(posedge clk);
    step();
    #1;
    access(4'd1, 4'd5, 8'hC3, 4, wsb, rv);
    lit("s6_cnt", 32'(xfer_cnt), 0);
    lit("s6_ws", 32'(wsb), 32'h2);
    lit("s6_ws_n", 32'($countones(wsb)), 1);
    cyc(1'b0, 1'b0);

    @(negedge clk);
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
